dcpu16_mctl: RTL and testbench

Memory controller directly downstream of the CPU memory bus stage. Serves the G-BUS (operand reads) and F-BUS (instruction fetch / result write) requests from one synchronous single-port SRAM. Returns per-bus read data and acks. Acks are held so that both buses complete together, matching the CPU stall rule ena = (f_stb ~^ f_ack) & (g_stb ~^ g_ack).

---
 rtl/dcpu16_mctl.sv | 188 ++++++++++++++++++
 tb/tb_dcpu16_mctl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu16_mctl.sv
// dcpu16_mctl: memory controller for the DCPU16 core.
// Serves G-BUS operand reads and F-BUS fetch/write requests from one
// synchronous single-port SRAM. The SRAM returns read data one cycle after
// it samples m_ce. Acks are level signals that are held until both buses can
// advance together: adv = (f_stb ~^ f_ack) & (g_stb ~^ g_ack).
// Optional build macro DCPU16_MCTL_STALL_CNT_EN enables the saturating
// contention counter on stall_cnt. Without the macro, stall_cnt is tied to 0.
module dcpu16_mctl #(
  parameter int AW     = 16,
  parameter int PRIO_G = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  output logic [15:0]   g_dti,
  output logic          g_ack,
  input  logic [15:0]   f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [15:0]   f_dto,
  output logic [15:0]   f_dti,
  output logic          f_ack,
  output logic [AW-1:0] m_adr,
  output logic          m_ce,
  output logic          m_we,
  output logic [15:0]   m_dto,
  input  logic [15:0]   m_dti,
  output logic [15:0]   stall_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISS1 = 2'd1;
  localparam logic [1:0] ISS2 = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic PRIO_G_B = (PRIO_G != 0);

  // Access pipeline: p0 = issued this cycle (SRAM sampling),
  // p1 = SRAM read data on m_dti. bus_pN is 0 for G, 1 for F.
  logic       vld_p0, bus_p0, we_p0;
  logic       vld_p1, bus_p1, we_p1;

  logic [1:0] state, state_n;
  logic       g_cxl, f_cxl;
  logic       g_ack_n, f_ack_n;

  logic       adv;
  logic       g_busy, f_busy;
  logic       g_elig, f_elig;
  logic       g_win, f_win, issue, contend;
  logic       g_done, f_done;
  logic       g_dlv, f_dlv;
  logic [1:0] inflight_n;

  // Upper address bits beyond AW are intentionally ignored.
  logic       unused_bits;
  assign unused_bits = ^{g_adr, f_adr};

  assign adv = (f_stb ~^ f_ack) & (g_stb ~^ g_ack);

  assign g_busy = (vld_p0 & ~bus_p0) | (vld_p1 & ~bus_p1);
  assign f_busy = (vld_p0 &  bus_p0) | (vld_p1 &  bus_p1);

  // A bus with an ack pending or an access in flight cannot issue again.
  assign g_elig = g_stb & ~g_ack & ~g_busy & (state != ISS2);
  assign f_elig = f_stb & ~f_ack & ~f_busy & (state != ISS2);

  assign contend = g_elig & f_elig;
  assign g_win   = g_elig & (~f_elig |  PRIO_G_B);
  assign f_win   = f_elig & (~g_elig | ~PRIO_G_B);
  assign issue   = g_win | f_win;

  assign g_done = vld_p1 & ~bus_p1;
  assign f_done = vld_p1 &  bus_p1;

  // A withdrawn strobe anywhere during the access suppresses delivery.
  assign g_dlv = g_done & g_stb & ~g_cxl;
  assign f_dlv = f_done & f_stb & ~f_cxl;

  assign inflight_n = {1'b0, issue} + {1'b0, vld_p0};

  // Next ack levels and FSM state from issue, completion and adv events.
  always_comb begin
    g_ack_n = g_ack;
    f_ack_n = f_ack;
    if (adv) begin
      g_ack_n = 1'b0;
      f_ack_n = 1'b0;
    end
    if (g_dlv) g_ack_n = 1'b1;
    if (f_dlv) f_ack_n = 1'b1;
    state_n = IDLE;
    case (inflight_n)
      2'd2:    state_n = ISS2;
      2'd1:    state_n = ISS1;
      default: state_n = (g_ack_n | f_ack_n) ? HOLD : IDLE;
    endcase
  end

  // Issue stage -> SRAM sample stage -> read-data capture stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      bus_p0 <= 1'b0;
      we_p0  <= 1'b0;
      vld_p1 <= 1'b0;
      bus_p1 <= 1'b0;
      we_p1  <= 1'b0;
    end else begin
      vld_p0 <= issue;
      bus_p0 <= f_win;
      we_p0  <= f_win ? f_wre : g_wre;
      vld_p1 <= vld_p0;
      bus_p1 <= bus_p0;
      we_p1  <= we_p0;
    end
  end

  // SRAM port registers; address and write data hold between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ce  <= 1'b0;
      m_we  <= 1'b0;
      m_adr <= '0;
      m_dto <= 16'h0000;
    end else begin
      m_ce <= issue;
      m_we <= issue & (f_win ? f_wre : g_wre);
      if (issue) begin
        m_adr <= f_win ? f_adr[AW-1:0] : g_adr[AW-1:0];
        m_dto <= f_win ? f_dto : 16'h0000;
      end
    end
  end

  // Sticky cancel flags for strobes withdrawn while an access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cxl <= 1'b0;
      f_cxl <= 1'b0;
    end else begin
      if (g_done)                g_cxl <= 1'b0;
      else if (g_busy && !g_stb) g_cxl <= 1'b1;
      if (f_done)                f_cxl <= 1'b0;
      else if (f_busy && !f_stb) f_cxl <= 1'b1;
    end
  end

  // Ack levels and returned read data; writes leave x_dti unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_ack <= 1'b0;
      f_ack <= 1'b0;
      g_dti <= 16'h0000;
      f_dti <= 16'h0000;
    end else begin
      g_ack <= g_ack_n;
      f_ack <= f_ack_n;
      if (g_dlv && !we_p1) g_dti <= m_dti;
      if (f_dlv && !we_p1) f_dti <= m_dti;
    end
  end

  // Controller state tracking accesses in flight and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

`ifdef DCPU16_MCTL_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count edges where one eligible bus lost arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stall_cnt <= 16'h0000;
    else if (contend) stall_cnt <= sat_inc(stall_cnt);
  end
`else
  logic unused_contend;
  assign unused_contend = contend;
  assign stall_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_dcpu16_mctl.sv
// Testbench for dcpu16_mctl (AW=10, PRIO_G=1): directed scenarios plus
// randomized traffic against a transaction-timestamp reference model.
`timescale 1ns/1ps
module tb_dcpu16_mctl;
  localparam int AW     = 10;
  localparam int PRIO_G = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   g_adr, f_adr, f_dto, g_dti, f_dti, m_dto, m_dti, stall_cnt;
  logic          g_stb, g_wre, g_ack, f_stb, f_wre, f_ack, m_ce, m_we;
  logic [AW-1:0] m_adr;

  dcpu16_mctl #(.AW(AW), .PRIO_G(PRIO_G)) dut (
    .clk(clk), .rst(rst),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dti(g_dti), .g_ack(g_ack),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .m_adr(m_adr), .m_ce(m_ce), .m_we(m_we), .m_dto(m_dto), .m_dti(m_dti),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // SRAM device with preload port
  logic [15:0]   sram [0:DEPTH-1];
  logic          pre_en;
  logic [AW-1:0] pre_adr;
  logic [15:0]   pre_dat;
  always @(posedge clk) begin
    if (pre_en) sram[pre_adr] <= pre_dat;
    else if (m_ce) begin
      if (m_we) sram[m_adr] <= m_dto;
      m_dti <= sram[m_adr];
    end
  end

  // Reference model: each bus has at most one request, tracked by issue time.
  typedef struct {
    int            t;
    logic [AW-1:0] a;
    logic          w;
    logic [15:0]   wd;
    logic [15:0]   rd;
    logic          x;
  } req_t;

  req_t          rq [2];
  logic          e_ack [2];
  logic [15:0]   e_dti [2];
  logic          e_m_ce, e_m_we;
  logic [AW-1:0] e_m_adr;
  logic [15:0]   e_m_dto, e_stall;
  logic [15:0]   ref_mem [0:DEPTH-1];
  int            cyc;
  int            n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      rq[b].t = -1; rq[b].x = 1'b0; rq[b].w = 1'b0;
      rq[b].a = '0; rq[b].wd = 16'h0; rq[b].rd = 16'h0;
      e_ack[b] = 1'b0; e_dti[b] = 16'h0;
    end
    e_m_ce = 1'b0; e_m_we = 1'b0; e_m_adr = '0; e_m_dto = 16'h0; e_stall = 16'h0;
    cyc = 0;
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    logic        stb [2];
    logic        wre [2];
    logic        elig [2];
    logic        set [2];
    logic [15:0] adr [2];
    logic        adv;
    int          win;
    stb[0] = g_stb; stb[1] = f_stb;
    wre[0] = g_wre; wre[1] = f_wre;
    adr[0] = g_adr; adr[1] = f_adr;
    adv = (stb[1] == e_ack[1]) && (stb[0] == e_ack[0]);
    for (int b = 0; b < 2; b++) begin
      elig[b] = stb[b] && !e_ack[b] && (rq[b].t < 0);
      set[b]  = 1'b0;
      if (rq[b].t >= 0) begin
        if (!stb[b]) rq[b].x = 1'b1;
        if (cyc == rq[b].t + 1) begin
          if (rq[b].w) ref_mem[rq[b].a] = rq[b].wd;
          else         rq[b].rd = ref_mem[rq[b].a];
        end else if (cyc == rq[b].t + 2) begin
          if (!rq[b].x) begin
            set[b] = 1'b1;
            if (!rq[b].w) e_dti[b] = rq[b].rd;
          end
          rq[b].t = -1;
          rq[b].x = 1'b0;
        end
      end
    end
    for (int b = 0; b < 2; b++) begin
      if (adv)    e_ack[b] = 1'b0;
      if (set[b]) e_ack[b] = 1'b1;
    end
    win = -1;
    if (elig[0] && elig[1]) begin
      win = (PRIO_G != 0) ? 0 : 1;
`ifdef DCPU16_MCTL_STALL_CNT_EN
      if (e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
`endif
    end else if (elig[0]) win = 0;
    else if (elig[1]) win = 1;
    e_m_ce = (win >= 0);
    e_m_we = 1'b0;
    if (win >= 0) begin
      rq[win].t  = cyc;
      rq[win].a  = adr[win][AW-1:0];
      rq[win].w  = wre[win];
      rq[win].wd = (win == 1) ? f_dto : 16'h0000;
      rq[win].x  = 1'b0;
      e_m_we  = wre[win];
      e_m_adr = rq[win].a;
      e_m_dto = rq[win].wd;
    end
    cyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("g_ack", g_ack, e_ack[0]);
    chk("f_ack", f_ack, e_ack[1]);
    chk("g_dti", g_dti, e_dti[0]);
    chk("f_dti", f_dti, e_dti[1]);
    chk("m_ce", m_ce, e_m_ce);
    chk("m_we", m_we, e_m_we);
    chk("m_adr", m_adr, e_m_adr);
    chk("m_dto", m_dto, e_m_dto);
    chk("stall_cnt", stall_cnt, e_stall);
  endtask

  function automatic logic [15:0] rand_adr();
    logic [15:0] a;
    a = 16'($urandom);
    a[9:6] = 4'b0000;
    return a;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_g_ack"}, g_ack, 0);
    chk({tag, "_f_ack"}, f_ack, 0);
    chk({tag, "_g_dti"}, g_dti, 0);
    chk({tag, "_f_dti"}, f_dti, 0);
    chk({tag, "_m_ce"}, m_ce, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_adr"}, m_adr, 0);
    chk({tag, "_m_dto"}, m_dto, 0);
    chk({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; pre_en = 1'b0; pre_adr = '0; pre_dat = 16'h0;
    g_adr = 16'h0; g_stb = 1'b0; g_wre = 1'b0;
    f_adr = 16'h0; f_stb = 1'b0; f_wre = 1'b0; f_dto = 16'h0;
    model_reset();

    // Preload SRAM while in reset
    for (int i = 0; i < 64; i++) begin
      pre_adr = AW'(i);
      pre_dat = (i == 16) ? 16'hBEEF : (i == 32) ? 16'h5555 : 16'($urandom);
      ref_mem[i] = pre_dat;
      pre_en = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;
    chk_all_zero("reset");
    rst = 1'b0;
    model_reset();
    step();

    // G-only read
    g_adr = 16'h0010; g_stb = 1'b1;
    step();
    chk("t1_m_adr", m_adr, 10'h010);
    step();
    chk("t1_ack_early", g_ack, 0);
    step();
    chk("t1_ack", g_ack, 1);
    chk("t1_dti", g_dti, 16'hBEEF);
    step();
    chk("t1_clr", g_ack, 0);
    chk("t1_dti_hold", g_dti, 16'hBEEF);
    g_stb = 1'b0;
    step();

    // Simultaneous read and write, G wins; G ack held until F ack
    g_adr = 16'h0020; g_stb = 1'b1;
    f_adr = 16'h0020; f_wre = 1'b1; f_dto = 16'h1234; f_stb = 1'b1;
    step();
    chk("t2_first_we", m_we, 0);
    step();
    chk("t2_second_we", m_we, 1);
    step();
    chk("t2_g_ack", g_ack, 1);
    chk("t2_g_dti", g_dti, 16'h5555);
    chk("t2_f_ack_early", f_ack, 0);
    step();
    chk("t2_g_hold", g_ack, 1);
    chk("t2_f_ack", f_ack, 1);
    chk("t2_g_dti_hold", g_dti, 16'h5555);
`ifdef DCPU16_MCTL_STALL_CNT_EN
    chk("t2_stall", stall_cnt, 1);
`endif
    step();
    chk("t2_g_clr", g_ack, 0);
    chk("t2_f_clr", f_ack, 0);
    g_stb = 1'b0; f_stb = 1'b0; f_wre = 1'b0;
    step();
    chk("t2_mem", sram[32], 16'h1234);

    // Strobe withdrawn after a write issues
    f_adr = 16'h0030; f_wre = 1'b1; f_dto = 16'hABCD; f_stb = 1'b1;
    step();
    f_stb = 1'b0;
    step();
    step();
    chk("t3_no_ack", f_ack, 0);
    step();
    chk("t3_no_ack_late", f_ack, 0);
    chk("t3_mem", sram[48], 16'hABCD);
    f_wre = 1'b0;

    // Async reset with two accesses in flight
    g_adr = 16'h0001; g_stb = 1'b1;
    f_adr = 16'h0002; f_stb = 1'b1;
    step();
    step();
    chk("t4_ce_before", m_ce, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t4_async");
    g_stb = 1'b0; f_stb = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Address wrap and normal latency after reset
    g_adr = 16'h0405; g_stb = 1'b1;
    step();
    chk("t5_m_adr", m_adr, 10'h005);
    step();
    step();
    chk("t5_ack", g_ack, 1);
    chk("t5_dti", g_dti, ref_mem[5]);
    step();
    g_stb = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        g_stb = ($urandom_range(0, 3) != 0);
        g_adr = rand_adr();
        g_wre = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        f_stb = ($urandom_range(0, 3) != 0);
        f_adr = rand_adr();
        f_wre = $urandom_range(0, 1) != 0;
        f_dto = 16'($urandom);
      end
      step();
    end
    g_stb = 1'b0; f_stb = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 64; i++) chk("mem", sram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
